// File: rtl/fasm_reg_bank.sv
// ---------------------------------------------------------------------------
// fasm_reg_bank
//
// Small parameterised control/status register bank. Each register is one of
// four kinds, chosen per register by the mask parameters:
//   RO    - samples hw_in every cycle and ignores writes (a write is an error)
//   W1C   - sticky bits set by hw_set, cleared by writing ones
//   PULSE - holds written data for one cycle, then returns to zero
//   RW    - plain read/write storage
// If masks overlap, the priority is RO > W1C > PULSE > RW.
//
// Reads are registered: re in cycle N gives rd_valid and dout in cycle N+1.
// dout shows the value the register had in cycle N. A read and a write can
// happen in the same cycle, and the bank never stalls.
//
// Ports
//   clk       in   single rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   we        in   write strobe
//   adr_wr    in   write address (DATA_WIDTH)
//   din       in   write data (DATA_WIDTH)
//   re        in   read strobe
//   adr_rd    in   read address (DATA_WIDTH)
//   dout      out  registered read data; holds while rd_valid is low
//   rd_valid  out  one-cycle pulse marking dout as fresh
//   wr_err    out  one-cycle pulse after an out-of-range or read-only write
//   hw_in     in   per-register values for RO registers, slice i at
//                  [i*DATA_WIDTH +: DATA_WIDTH]
//   hw_set    in   per-bit set events for W1C registers, same slicing
//   regs_out  out  live contents of every register, same slicing
// ---------------------------------------------------------------------------
module fasm_reg_bank #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  NUM_REGS   = 4,
    parameter int                  BASE_ADDR  = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           we,
    input  logic [DATA_WIDTH-1:0]          adr_wr,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           re,
    input  logic [DATA_WIDTH-1:0]          adr_rd,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           rd_valid,
    output logic                           wr_err,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    // Address arithmetic runs one bit wider than both the address and the
    // integer base. This way an address below the base, or a base near the
    // top of the address space, can never wrap around to a valid index.
    localparam int AW = ((DATA_WIDTH > 32) ? DATA_WIDTH : 32) + 1;

    logic [AW-1:0]         base_ext;
    logic [AW-1:0]         wr_ext;
    logic [AW-1:0]         rd_ext;
    logic [AW-1:0]         wr_off;
    logic [AW-1:0]         rd_off;
    logic                  wr_ge;
    logic                  rd_ge;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [NUM_REGS-1:0]   rd_sel;
    logic                  wr_hit;
    logic                  wr_ro;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_d [NUM_REGS];

    assign base_ext = AW'(BASE_ADDR);
    assign wr_ext   = AW'(adr_wr);
    assign rd_ext   = AW'(adr_rd);
    assign wr_ge    = (wr_ext >= base_ext);
    assign rd_ge    = (rd_ext >= base_ext);
    assign wr_off   = wr_ext - base_ext;
    assign rd_off   = rd_ext - base_ext;

    // One-hot register select for each port. An address outside the bank
    // selects nothing.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = we && wr_ge && (wr_off == AW'(i));
            rd_sel[i] = rd_ge && (rd_off == AW'(i));
        end
    end

    assign wr_hit = |wr_sel;
    assign wr_ro  = |(wr_sel & RO_MASK);

    // Next value of each register, by mode. In W1C mode the set term is
    // ORed in after the clear, so a set wins over a clear on the same bit.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                reg_d[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (W1C_MASK[i]) begin
                reg_d[i] = (reg_q[i] & ~(wr_sel[i] ? din : '0))
                         | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (PULSE_MASK[i]) begin
                reg_d[i] = wr_sel[i] ? din : '0;
            end else begin
                reg_d[i] = wr_sel[i] ? din : reg_q[i];
            end
        end
    end

    // Read mux. It uses the current register value, so a write to the same
    // register in the same cycle is not seen by this read. An out-of-range
    // read returns zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_data = reg_q[i];
            end
        end
    end

    // State and registered outputs. Reset clears everything at once,
    // including any read response still in flight and any PULSE value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= '0;
            end
            dout     <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= reg_d[i];
            end
            rd_valid <= re;
            if (re) begin
                dout <= rd_data;
            end
            wr_err <= (we && !wr_hit) || wr_ro;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_q[i];
        end
    end

endmodule
